glitch_filter: RTL
==================

Name: glitch_filter

Overview:
- Multi-channel input conditioner that sits between asynchronous, hazard-prone combinational sources and synchronous logic.
- Each channel is synchronised into the clock domain.
- A level change propagates to the output only after it has been stable for FILTER_CYCLES consecutive clocks.
- Shorter excursions are suppressed, flagged per channel and counted in a saturating counter shared by all channels.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: flip-flops in each input synchroniser (>=2).
- FILTER_CYCLES, 4: consecutive clocks a new level must persist before it is accepted (>=1).
- CNT_WIDTH, 8: width of the glitch counter.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iEnable  input  1  filter enable; low freezes the outputs.
- iClearCount  input  1  synchronous clear of oGlitchCount.
- iD  input  CHANNELS  raw asynchronous inputs.
- oQ  output  CHANNELS  filtered, registered levels.
- oRise  output  CHANNELS  one-cycle pulse when oQ[n] goes 0->1.
- oFall  output  CHANNELS  one-cycle pulse when oQ[n] goes 1->0.
- oGlitch  output  CHANNELS  one-cycle pulse when a rejected excursion ends.
- oGlitchCount  output  CNT_WIDTH  saturating total of rejected excursions.

Behaviour:
- Reset: iRst_n low asynchronously clears, without waiting for a clock edge:
  - all synchroniser flops, channel FSMs and run counters;
  - oQ, oRise, oFall, oGlitch and oGlitchCount, all to 0.
  - Reset asserted mid-qualification discards the pending event; no pulse is emitted.
- Synchroniser: iD[n] passes through SYNC_STAGES flops. s[n] is the last stage.
- Per-channel FSM, two states, evaluated each clock while iEnable=1:
  - STABLE:
    - s[n]==oQ[n]: remain.
    - s[n]!=oQ[n]: if FILTER_CYCLES==1, update oQ[n] immediately; otherwise go to PENDING with run=1.
  - PENDING, s[n]!=oQ[n]:
    - run==FILTER_CYCLES-1: oQ[n]<=s[n], pulse oRise[n] or oFall[n] on the same edge, go to STABLE, run=0.
    - otherwise: run<=run+1.
  - PENDING, s[n]==oQ[n]: pulse oGlitch[n], go to STABLE, run=0, oQ[n] unchanged.
- Qualification rule: oQ[n] changes only after s[n] has differed from it on FILTER_CYCLES consecutive sampling edges.
  - Net latency from an iD change (set up before edge 0) to oQ change is SYNC_STAGES+FILTER_CYCLES clocks: 6 at defaults.
  - An excursion lasting 1..FILTER_CYCLES-1 cycles at s produces exactly one oGlitch pulse and no edge pulse.
  - FILTER_CYCLES==1 never produces a glitch.
- Run counter width: clog2(FILTER_CYCLES+1). It never exceeds FILTER_CYCLES-1.
- Pulses: oRise, oFall and oGlitch are registered and high for exactly one clock. All channels operate independently and may pulse in the same cycle.
- Glitch counter:
  - Each clock, add popcount(oGlitch next-state) to oGlitchCount.
  - Saturate at 2^CNT_WIDTH-1; never wrap.
  - iClearCount=1 forces 0 and takes priority over same-cycle increments; those glitches are dropped.
- Enable: while iEnable=0:
  - synchronisers keep running;
  - FSMs are held in STABLE with run=0;
  - oQ holds its value;
  - no pulses are generated and the counter only responds to iClearCount.
  - Dropping iEnable mid-PENDING discards the event with no oGlitch.
  - On re-enable, a channel with s!=oQ starts a fresh full qualification.

Test Plan:
- Reset: hold iRst_n=0, toggle iD=4'b1111 -> all outputs 0 throughout. Assert iRst_n low between edges while channel 0 is PENDING -> oQ/oGlitchCount clear before the next edge, no pulses after release.
- Accept: iD[0] 0->1 held 10 clocks -> oQ[0]=1 exactly 6 clocks after the change, oRise[0] high for that single clock, oGlitch=0, count=0. Release to 0 -> oFall[0] after 6 clocks.
- Reject boundary: iD[1] high for 3 clocks -> oQ[1] stays 0, one oGlitch[1] pulse, count=1. High for 4 clocks -> oQ[1] rises, count still 1.
- Simultaneous/saturation: 2-clock pulses on channels 0, 2, 3 in the same cycle -> oGlitch=4'b1101 for one clock, count +3. Drive count to 254, then 2 glitches -> count=255 and holds. Glitch coinciding with iClearCount -> count=0.
- Enable: iD[2] rises, iEnable=0 two clocks later -> no oQ change, no oGlitch. Re-enable with iD[2] still high -> oQ[2] rises 4 clocks after re-enable.
- Parameter sweep: CHANNELS=1, FILTER_CYCLES=1 -> oQ follows iD after 3 clocks, oGlitch never asserted. CHANNELS=8, FILTER_CYCLES=7 -> 6-cycle pulse rejected, 7-cycle pulse accepted.

Source files
------------

// File: rtl/glitch_filter.sv
// Multi-channel input conditioner: synchronises each raw input, accepts a new level only
// after it persists for FILTER_CYCLES clocks, and flags and counts shorter excursions.
module glitch_filter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic                 iClearCount,
  input  logic [CHANNELS-1:0]  iD,
  output logic [CHANNELS-1:0]  oQ,
  output logic [CHANNELS-1:0]  oRise,
  output logic [CHANNELS-1:0]  oFall,
  output logic [CHANNELS-1:0]  oGlitch,
  output logic [CNT_WIDTH-1:0] oGlitchCount
);

  localparam int unsigned RUN_W = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned PC_W  = $clog2(CHANNELS + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + PC_W;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_CYCLES - 1);
  localparam logic [SUM_W-1:0] CNT_MAX  = (SUM_W'(1) << CNT_WIDTH) - SUM_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] s;
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [RUN_W-1:0]    run_q   [CHANNELS];
  logic [RUN_W-1:0]    run_d   [CHANNELS];
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]     pop;
  logic [SUM_W-1:0]    sum;

  // Input synchroniser shift chain; the last stage is the sampled level.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = iD;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel qualification FSM.
  always_comb begin
    q_d      = q_q;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      run_d[ch]   = run_q[ch];
      if (!iEnable) begin
        state_d[ch] = ST_STABLE;
        run_d[ch]   = '0;
      end else begin
        case (state_q[ch])
          ST_STABLE: begin
            if (s[ch] != q_q[ch]) begin
              if (FILTER_CYCLES == 1) begin
                q_d[ch]    = s[ch];
                rise_d[ch] = s[ch];
                fall_d[ch] = ~s[ch];
              end else begin
                state_d[ch] = ST_PENDING;
                run_d[ch]   = RUN_W'(1);
              end
            end
          end
          ST_PENDING: begin
            if (s[ch] != q_q[ch]) begin
              if (run_q[ch] == RUN_LAST) begin
                q_d[ch]     = s[ch];
                rise_d[ch]  = s[ch];
                fall_d[ch]  = ~s[ch];
                state_d[ch] = ST_STABLE;
                run_d[ch]   = '0;
              end else begin
                run_d[ch] = run_q[ch] + RUN_W'(1);
              end
            end else begin
              glitch_d[ch] = 1'b1;
              state_d[ch]  = ST_STABLE;
              run_d[ch]    = '0;
            end
          end
          default: begin
            state_d[ch] = ST_STABLE;
            run_d[ch]   = '0;
          end
        endcase
      end
    end
  end

  // Shared saturating glitch counter; clear wins over same-cycle increments.
  always_comb begin
    pop = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      pop = pop + PC_W'(glitch_d[ch]);
    end
    sum   = SUM_W'(cnt_q) + SUM_W'(pop);
    cnt_d = cnt_q;
    if (iClearCount) begin
      cnt_d = '0;
    end else if (sum > CNT_MAX) begin
      cnt_d = CNT_WIDTH'(CNT_MAX);
    end else begin
      cnt_d = CNT_WIDTH'(sum);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q   <= '0;
      q_q      <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
      cnt_q    <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= ST_STABLE;
        run_q[ch]   <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      cnt_q    <= cnt_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        run_q[ch]   <= run_d[ch];
      end
    end
  end

  assign oQ           = q_q;
  assign oRise        = rise_q;
  assign oFall        = fall_q;
  assign oGlitch      = glitch_q;
  assign oGlitchCount = cnt_q;

endmodule
